// File: rtl/mips_defs_pkg.sv
// Shared MIPS definitions: opcode/funct codes, trap vectors, privilege states
// and the decoded next-PC bundle handed from next_pc_calc to pc_sequencer.
package mips_defs_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  localparam logic [4:0] REG_K0     = 5'd26;

  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] INT_VEC   = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC   = 32'h8000_0008;

  typedef enum logic [1:0] {USER, KERNEL, GUARD} cpu_state_e;

  typedef struct packed {
    logic        is_jr;
    logic        is_j;
    logic        is_br;
    logic [31:0] jr_tgt;
    logic [31:0] j_tgt;
    logic [31:0] br_tgt;
  } npc_t;

endpackage

// File: rtl/next_pc_calc.sv
// Instruction-class decode and jump/branch target arithmetic; purely combinational.
module next_pc_calc
  import mips_defs_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  output npc_t        npc
);

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [31:0] br_off;

  assign op     = instr[31:26];
  assign fn     = instr[5:0];
  assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    npc        = '0;
    npc.is_jr  = (op == OP_SPECIAL) && ((fn == FN_JR) || (fn == FN_JALR));
    npc.is_j   = (op == OP_J) || (op == OP_JAL);
    npc.is_br  = (op == OP_REGIMM) || (op == OP_BEQ) || (op == OP_BNE) ||
                 (op == OP_BLEZ) || (op == OP_BGTZ);
    // misaligned register targets are silently aligned
    npc.jr_tgt = rs_data & 32'hFFFF_FFFC;
    npc.j_tgt  = {pc_plus4[31:28], instr[25:0], 2'b00};
    npc.br_tgt = pc_plus4 + br_off;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: next-PC priority select, trap vectoring, and the
// USER/KERNEL/GUARD privilege tracker that gates interrupt acceptance.
module pc_sequencer
  import mips_defs_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VEC,
  parameter logic [31:0] INT_VECTOR   = INT_VEC,
  parameter logic [31:0] EXC_VECTOR   = EXC_VEC,
  parameter int unsigned GUARD_CYCLES = 1
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instr,
  input  logic        branch_taken,
  input  logic [31:0] rs_data,
  input  logic        irq,
  input  logic        exc_req,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        kernel,
  output logic        squash,
  output logic        k0_we,
  output logic [31:0] k0_data
);

  cpu_state_e  state;
  logic [2:0]  gcnt;
  logic        irq_pending;
  logic        take_exc;
  logic        take_irq;
  logic [31:0] pc_next;
  npc_t        npc;

  assign pc_plus4 = pc + 32'd4;
  assign kernel   = pc[31];

  next_pc_calc u_npc (
    .pc_plus4 (pc_plus4),
    .instr    (instr),
    .rs_data  (rs_data),
    .npc      (npc)
  );

  always_comb begin
    take_exc = !reset && !stall && exc_req;
    take_irq = !reset && !stall && !exc_req && irq_pending && (state == USER);
    squash   = take_exc || take_irq;
    k0_we    = squash;
    // an interrupted instruction re-executes, an excepting one is skipped
    k0_data  = take_exc ? pc_plus4 : (take_irq ? pc : 32'd0);

    pc_next = pc_plus4;
    if (stall)                           pc_next = pc;
    else if (take_exc)                   pc_next = EXC_VECTOR;
    else if (take_irq)                   pc_next = INT_VECTOR;
    else if (npc.is_jr)                  pc_next = npc.jr_tgt;
    else if (npc.is_j)                   pc_next = npc.j_tgt;
    else if (npc.is_br && branch_taken)  pc_next = npc.br_tgt;

    // user code can only reach kernel space through a trap
    if (!stall && !squash && (state != KERNEL)) pc_next[31] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_VECTOR;
      irq_pending <= 1'b0;
      gcnt        <= 3'd0;
      state       <= KERNEL;
    end else begin
      pc          <= pc_next;
      irq_pending <= irq;
      if (!stall) begin
        case (state)
          KERNEL: if (!pc_next[31]) begin
            state <= GUARD;
            gcnt  <= 3'(GUARD_CYCLES);
          end
          GUARD: if (squash) begin
            state <= KERNEL;
            gcnt  <= 3'd0;
          end else if (gcnt <= 3'd1) begin
            state <= USER;
            gcnt  <= 3'd0;
          end else begin
            gcnt  <= gcnt - 3'd1;
          end
          default: if (squash) state <= KERNEL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed test-plan walk plus randomized traffic, checked against a
// cycle-level behavioural model of PC flow, privilege and interrupt guard.
module tb_pc_sequencer;
  import mips_defs_pkg::*;

  localparam int GC = 1;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, irq, exc_req;
  logic [31:0] instr, rs_data;
  logic [31:0] pc, pc_plus4, k0_data;
  logic        kernel, squash, k0_we;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.GUARD_CYCLES(GC)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .instr        (instr),
    .branch_taken (branch_taken),
    .rs_data      (rs_data),
    .irq          (irq),
    .exc_req      (exc_req),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .kernel       (kernel),
    .squash       (squash),
    .k0_we        (k0_we),
    .k0_data      (k0_data)
  );

  // model: pc, sampled irq, user instructions still to retire before irqs open
  logic [31:0] m_pc, m_nxt;
  logic        m_pend, m_trap;
  logic        m_valid = 1'b0;
  int          m_guard;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] i_jr();
    return {6'h00, 5'd8, 15'd0, 6'h08};
  endfunction

  function automatic logic [31:0] i_j(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  function automatic logic [31:0] i_beq(input logic [15:0] imm);
    return {6'h04, 10'd0, imm};
  endfunction

  task automatic drive(input logic r, st, ex, iq, bt, input logic [31:0] ins, rs);
    logic [31:0] pc4, k0;
    logic        sq;
    logic [5:0]  op, fn;
    int          off;
    reset = r; stall = st; exc_req = ex; irq = iq; branch_taken = bt;
    instr = ins; rs_data = rs;
    #1;
    pc4 = m_pc + 32'd4;
    op  = ins[31:26];
    fn  = ins[5:0];
    off = int'($signed(ins[15:0])) * 4;
    sq  = 1'b0;
    k0  = 32'd0;
    if (r)       m_nxt = RESET_VEC;
    else if (st) m_nxt = m_pc;
    else if (ex) begin m_nxt = EXC_VEC; sq = 1'b1; k0 = pc4; end
    else if (m_pend && !m_pc[31] && m_guard == 0) begin
      m_nxt = INT_VEC; sq = 1'b1; k0 = m_pc;
    end
    else if (op == 6'd0 && (fn == 6'd8 || fn == 6'd9)) m_nxt = {rs[31:2], 2'b00};
    else if (op == 6'd2 || op == 6'd3) m_nxt = {pc4[31:28], ins[25:0], 2'b00};
    else if ((op == 6'd1 || (op >= 6'd4 && op <= 6'd7)) && bt) m_nxt = pc4 + 32'(off);
    else m_nxt = pc4;
    if (!r && !st && !sq && !m_pc[31]) m_nxt[31] = 1'b0;
    m_trap = sq;
    if (m_valid) begin
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, pc4);
      chk("kernel", kernel, m_pc[31]);
    end
    chk("squash", squash, sq);
    chk("k0_we", k0_we, sq);
    chk("k0_data", k0_data, k0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_pc = RESET_VEC; m_pend = 1'b0; m_guard = 0; m_valid = 1'b1;
    end else begin
      if (m_trap) m_guard = 0;
      else if (!stall) begin
        if (m_pc[31] && !m_nxt[31]) m_guard = GC;
        else if (!m_pc[31] && m_guard > 0) m_guard--;
      end
      m_pc   = m_nxt;
      m_pend = irq;
    end
    @(negedge clk);
  endtask

  task automatic run(input logic r, st, ex, iq, bt, input logic [31:0] ins, rs);
    drive(r, st, ex, iq, bt, ins, rs);
    tick();
  endtask

  initial begin : main
    logic [31:0] ins, rs;
    logic        irq_lvl;
    int          k;

    // reset and sequential kernel fetch
    run(1, 0, 0, 0, 0, NOP, 0);
    run(1, 0, 0, 0, 0, NOP, 0);
    chk("t1_pc0", pc, 32'h8000_0000);
    chk("t1_kernel", kernel, 1);
    run(0, 0, 0, 0, 0, NOP, 0);
    chk("t1_pc1", pc, 32'h8000_0004);
    drive(0, 0, 0, 0, 0, NOP, 0);
    chk("t1_k0we", k0_we, 0);
    tick();
    chk("t1_pc2", pc, 32'h8000_0008);

    // return to user with irq held: one guarded instruction, then trap
    run(0, 0, 0, 1, 0, i_jr(), 32'h0000_000C);
    chk("t2_pc", pc, 32'h0000_000C);
    chk("t2_user", kernel, 0);
    drive(0, 0, 0, 1, 0, NOP, 0);
    chk("t2_guard_sq", squash, 0);
    tick();
    chk("t2_pc_ret", pc, 32'h0000_0010);
    drive(0, 0, 0, 1, 0, NOP, 0);
    chk("t2_trap_sq", squash, 1);
    chk("t2_trap_k0", k0_data, 32'h0000_0010);
    tick();
    chk("t2_int_vec", pc, 32'h8000_0004);

    // branches and jump
    run(0, 0, 0, 0, 0, i_jr(), 32'h0000_0100);
    chk("t3_pc", pc, 32'h0000_0100);
    run(0, 0, 0, 0, 1, i_beq(16'hFFFF), 0);
    chk("t3_beq_t", pc, 32'h0000_0100);
    run(0, 0, 0, 0, 0, i_beq(16'hFFFF), 0);
    chk("t3_beq_nt", pc, 32'h0000_0104);
    run(0, 0, 0, 0, 0, i_j(26'h40), 0);
    chk("t3_j", pc, 32'h0000_0100);

    // exception beats pending irq; irq taken after return + guard
    run(0, 0, 0, 1, 0, i_j(26'h80), 0);
    chk("t4_pc", pc, 32'h0000_0200);
    drive(0, 0, 1, 1, 0, NOP, 0);
    chk("t4_exc_sq", squash, 1);
    chk("t4_exc_k0", k0_data, 32'h0000_0204);
    tick();
    chk("t4_exc_vec", pc, 32'h8000_0008);
    run(0, 0, 0, 1, 0, i_jr(), 32'h0000_0204);
    drive(0, 0, 0, 1, 0, NOP, 0);
    chk("t4_guard_sq", squash, 0);
    tick();
    drive(0, 0, 0, 1, 0, NOP, 0);
    chk("t4_irq_sq", squash, 1);
    chk("t4_irq_k0", k0_data, 32'h0000_0208);
    tick();
    chk("t4_int_vec", pc, 32'h8000_0004);

    // stall blocks the trap
    run(0, 0, 0, 1, 0, i_jr(), 32'h0000_02FC);
    run(0, 0, 0, 1, 0, NOP, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 0, NOP, 0);
      chk("t5_hold_pc", pc, 32'h0000_0300);
      chk("t5_hold_sq", squash, 0);
      tick();
    end
    drive(0, 0, 0, 1, 0, NOP, 0);
    chk("t5_trap_sq", squash, 1);
    chk("t5_trap_k0", k0_data, 32'h0000_0300);
    tick();
    chk("t5_int_vec", pc, 32'h8000_0004);

    // reset in a trap cycle
    run(0, 0, 0, 1, 0, i_jr(), 32'h0000_0400);
    run(0, 0, 0, 1, 0, NOP, 0);
    drive(1, 0, 0, 1, 0, NOP, 0);
    chk("t6_sq", squash, 0);
    chk("t6_k0we", k0_we, 0);
    tick();
    chk("t6_pc", pc, 32'h8000_0000);
    chk("t6_kernel", kernel, 1);
    run(0, 0, 0, 0, 0, NOP, 0);
    chk("t6_pc1", pc, 32'h8000_0004);

    // randomized traffic
    irq_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1:    ins = {6'h00, 20'($urandom), 6'h20};
        2:       ins = {6'h00, 20'($urandom), 6'($urandom_range(8, 9))};
        3:       ins = {6'($urandom_range(2, 3)), 26'($urandom)};
        4, 5:    ins = {6'($urandom_range(4, 7)), 26'($urandom)};
        6:       ins = {6'h01, 26'($urandom)};
        7:       ins = {6'h23, 26'($urandom)};
        default: ins = $urandom;
      endcase
      rs = $urandom;
      if (!m_pc[31]) rs[31] = 1'b0;
      if ($urandom_range(0, 9) == 0) irq_lvl = ~irq_lvl;
      run($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 15) == 0, irq_lvl, 1'($urandom_range(0, 1)), ins, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
